// File: rtl/ternary_pkg.sv
// Shared ternary-core types: trit encoding, word/address types, forward selects
// and the R0 test used by the hazard logic and the forwarding unit.
package ternary_pkg;

  localparam int TRIT_WORD_LEN = 9;

  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b10;

  typedef trit_t [TRIT_WORD_LEN-1:0] trit_word_t;
  typedef trit_t [2:0]               reg_addr_t;

  localparam reg_addr_t REG_R0 = {3{T_ZERO}};

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  function automatic logic is_r0(input reg_addr_t addr);
    return (addr == REG_R0);
  endfunction

endpackage

// File: rtl/ternary_id_ex_stage_if.sv
// ID/EX stage bus: decoded ID fields, EX controls/operands and forwarding inputs.
// master = upstream pipeline side, slave = the ID/EX register itself.
interface ternary_id_ex_stage_if #(
  parameter int WORD_TRITS = 9,
  parameter int ALU_OP_W   = 4
);
  import ternary_pkg::*;

  logic                        id_valid;
  trit_t [2:0]                 id_rs1;
  trit_t [2:0]                 id_rs2;
  trit_t [2:0]                 id_rd;
  trit_t [WORD_TRITS-1:0]      id_rs1_data;
  trit_t [WORD_TRITS-1:0]      id_rs2_data;
  trit_t [WORD_TRITS-1:0]      id_imm;
  logic                        id_reg_write;
  logic                        id_mem_read;
  logic                        id_use_rs2;
  logic                        id_use_imm;
  logic [ALU_OP_W-1:0]         id_alu_op;
  logic                        flush;
  logic                        ex_ready;
  logic [1:0]                  forward_a;
  logic [1:0]                  forward_b;
  trit_t [WORD_TRITS-1:0]      mem_result;
  trit_t [WORD_TRITS-1:0]      wb_result;

  logic                        id_stall;
  logic                        ex_valid;
  logic                        ex_reg_write;
  logic                        ex_mem_read;
  trit_t [2:0]                 ex_rs1;
  trit_t [2:0]                 ex_rs2;
  trit_t [2:0]                 ex_rd;
  logic [ALU_OP_W-1:0]         ex_alu_op;
  trit_t [WORD_TRITS-1:0]      ex_op_a;
  trit_t [WORD_TRITS-1:0]      ex_op_b;
  trit_t [WORD_TRITS-1:0]      ex_store_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_use_rs2, id_use_imm, id_alu_op,
           flush, ex_ready, forward_a, forward_b, mem_result, wb_result,
    input  id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_op_a, ex_op_b, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_reg_write, id_mem_read, id_use_rs2, id_use_imm, id_alu_op,
           flush, ex_ready, forward_a, forward_b, mem_result, wb_result,
    output id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rs1, ex_rs2, ex_rd,
           ex_alu_op, ex_op_a, ex_op_b, ex_store_data
  );

endinterface

// File: rtl/ternary_operand_mux.sv
// One EX operand: 3:1 forward select (11 behaves as regfile) followed by an
// optional immediate override.
module ternary_operand_mux
  import ternary_pkg::*;
#(
  parameter int WORD_TRITS = 9
) (
  input  logic [1:0]             fwd_sel,
  input  trit_t [WORD_TRITS-1:0] rf_data,
  input  trit_t [WORD_TRITS-1:0] wb_data,
  input  trit_t [WORD_TRITS-1:0] mem_data,
  input  trit_t [WORD_TRITS-1:0] imm_data,
  input  logic                   use_imm,
  output trit_t [WORD_TRITS-1:0] op_data
);

  trit_t [WORD_TRITS-1:0] fwd_s;

  // Forward source selection
  always_comb begin
    fwd_s = rf_data;
    case (fwd_sel)
      FWD_MEM: fwd_s = mem_data;
      FWD_WB:  fwd_s = wb_data;
      default: fwd_s = rf_data;
    endcase
  end

  assign op_data = use_imm ? imm_data : fwd_s;

endmodule

// File: rtl/ternary_id_ex_stage.sv
// ID/EX pipeline register with load-use detection, flush, backpressure hold and
// forwarded operand selection. Optional hazard counters: TERNARY_HAZARD_STATS_EN.
module ternary_id_ex_stage #(
  parameter int WORD_TRITS = 9,
  parameter int ALU_OP_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TERNARY_HAZARD_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stat_load_use,
  output logic [31:0] stat_backpressure,
  output logic [31:0] stat_flush,
`endif
  ternary_id_ex_stage_if.slave bus
);
  import ternary_pkg::*;

  typedef trit_t [WORD_TRITS-1:0] word_t;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                use_imm;
    reg_addr_t           rs1;
    reg_addr_t           rs2;
    reg_addr_t           rd;
    logic [ALU_OP_W-1:0] alu_op;
    word_t               rs1_data;
    word_t               rs2_data;
    word_t               imm;
  } ex_regs_t;

  // T_ZERO encodes as 2'b00, so an all-zero record is a clean bubble with rd=R0.
  localparam ex_regs_t EX_BUBBLE = '0;

  ex_regs_t ex_q;
  ex_regs_t ex_d;
  logic     rs1_hit_s;
  logic     rs2_hit_s;
  logic     load_use_s;

  assign rs1_hit_s  = (bus.id_rs1 == ex_q.rd);
  assign rs2_hit_s  = bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd);
  assign load_use_s = ex_q.valid & ex_q.mem_read & ~is_r0(ex_q.rd) &
                      bus.id_valid & (rs1_hit_s | rs2_hit_s);

  assign bus.id_stall = rst_n & (load_use_s | ~bus.ex_ready);

  // Next EX contents: flush, then hold, then load-use bubble, then capture
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = EX_BUBBLE;
    end else if (!bus.ex_ready) begin
      // WB retires during the hold, so pull its value into the operand register now.
      if (bus.forward_a == FWD_WB) begin
        ex_d.rs1_data = bus.wb_result;
      end else begin
        ex_d.rs1_data = ex_q.rs1_data;
      end
      if (bus.forward_b == FWD_WB) begin
        ex_d.rs2_data = bus.wb_result;
      end else begin
        ex_d.rs2_data = ex_q.rs2_data;
      end
    end else if (load_use_s || !bus.id_valid) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.use_imm   = bus.id_use_imm;
      ex_d.rs1       = bus.id_rs1;
      ex_d.rs2       = bus.id_rs2;
      ex_d.rd        = bus.id_rd;
      ex_d.alu_op    = bus.id_alu_op;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
    end
  end

  // EX register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_reg_write = ex_q.reg_write;
  assign bus.ex_mem_read  = ex_q.mem_read;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_alu_op    = ex_q.alu_op;

  ternary_operand_mux #(.WORD_TRITS(WORD_TRITS)) u_mux_a (
    .fwd_sel  (bus.forward_a),
    .rf_data  (ex_q.rs1_data),
    .wb_data  (bus.wb_result),
    .mem_data (bus.mem_result),
    .imm_data (ex_q.imm),
    .use_imm  (1'b0),
    .op_data  (bus.ex_op_a)
  );

  ternary_operand_mux #(.WORD_TRITS(WORD_TRITS)) u_mux_b (
    .fwd_sel  (bus.forward_b),
    .rf_data  (ex_q.rs2_data),
    .wb_data  (bus.wb_result),
    .mem_data (bus.mem_result),
    .imm_data (ex_q.imm),
    .use_imm  (ex_q.use_imm),
    .op_data  (bus.ex_op_b)
  );

  // Store data always takes the forwarded rs2 value, never the immediate.
  ternary_operand_mux #(.WORD_TRITS(WORD_TRITS)) u_mux_st (
    .fwd_sel  (bus.forward_b),
    .rf_data  (ex_q.rs2_data),
    .wb_data  (bus.wb_result),
    .mem_data (bus.mem_result),
    .imm_data (ex_q.imm),
    .use_imm  (1'b0),
    .op_data  (bus.ex_store_data)
  );

`ifdef TERNARY_HAZARD_STATS_EN
  logic [31:0] stat_lu_q;
  logic [31:0] stat_bp_q;
  logic [31:0] stat_fl_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  // Saturating hazard counters, synchronous clear has top priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu_q <= 32'd0;
      stat_bp_q <= 32'd0;
      stat_fl_q <= 32'd0;
    end else if (stat_clr) begin
      stat_lu_q <= 32'd0;
      stat_bp_q <= 32'd0;
      stat_fl_q <= 32'd0;
    end else begin
      stat_lu_q <= sat_inc(stat_lu_q, load_use_s);
      stat_bp_q <= sat_inc(stat_bp_q, ~bus.ex_ready);
      stat_fl_q <= sat_inc(stat_fl_q, bus.flush);
    end
  end

  assign stat_load_use     = stat_lu_q;
  assign stat_backpressure = stat_bp_q;
  assign stat_flush        = stat_fl_q;
`endif

endmodule

// File: tb/tb_ternary_id_ex_stage.sv
// Bench for ternary_id_ex_stage: directed hazard/flush/hold scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_ternary_id_ex_stage;
  import ternary_pkg::*;

  localparam int WT = 9;
  typedef trit_t [WT-1:0] word_t;

  typedef struct packed {
    logic      valid;
    logic      rw;
    logic      mr;
    logic      imm_en;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic [3:0] op;
    word_t     a;
    word_t     b;
    word_t     imm;
  } inst_t;

  localparam reg_addr_t R0 = 6'h00;
  localparam reg_addr_t R1 = 6'h01;
  localparam reg_addr_t R2 = 6'h04;
  localparam reg_addr_t R3 = 6'h10;
  localparam reg_addr_t R4 = 6'h02;

  localparam word_t W_A   = 18'h15555;
  localparam word_t W_B   = 18'h2AAAA;
  localparam word_t W_M   = 18'h11111;
  localparam word_t W_W   = 18'h22222;
  localparam word_t W_M2  = 18'h05050;
  localparam word_t W_S   = 18'h04444;
  localparam word_t W_W2  = 18'h08888;
  localparam word_t W_IMM = 18'h18000;
  localparam word_t W_Z   = 18'h00000;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic started = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  inst_t m;

  always #5 clk = ~clk;

  ternary_id_ex_stage_if #(.WORD_TRITS(WT), .ALU_OP_W(4)) bus ();

`ifdef TERNARY_HAZARD_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] s_lu;
  logic [31:0] s_bp;
  logic [31:0] s_fl;
`endif

  ternary_id_ex_stage #(.WORD_TRITS(WT), .ALU_OP_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
`ifdef TERNARY_HAZARD_STATS_EN
    .stat_clr          (stat_clr),
    .stat_load_use     (s_lu),
    .stat_backpressure (s_bp),
    .stat_flush        (s_fl),
`endif
    .bus               (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // EX holds a load writing a non-R0 register that the ID instruction reads.
  function automatic logic hazard(input inst_t cur);
    return cur.valid && cur.mr && (cur.rd != R0) && bus.id_valid &&
           ((bus.id_rs1 == cur.rd) || (bus.id_use_rs2 && (bus.id_rs2 == cur.rd)));
  endfunction

  function automatic word_t pick(input logic [1:0] f, input word_t rf);
    if (f == 2'b10) return bus.mem_result;
    if (f == 2'b01) return bus.wb_result;
    return rf;
  endfunction

  function automatic inst_t model_next(input inst_t cur);
    inst_t n;
    n = cur;
    if (bus.flush) begin
      n = '0;
    end else if (!bus.ex_ready) begin
      if (bus.forward_a == 2'b01) n.a = bus.wb_result;
      if (bus.forward_b == 2'b01) n.b = bus.wb_result;
    end else if (hazard(cur) || !bus.id_valid) begin
      n = '0;
    end else begin
      n.valid = 1'b1;          n.rw  = bus.id_reg_write;
      n.mr    = bus.id_mem_read; n.imm_en = bus.id_use_imm;
      n.rs1   = bus.id_rs1;    n.rs2 = bus.id_rs2;  n.rd = bus.id_rd;
      n.op    = bus.id_alu_op; n.a   = bus.id_rs1_data;
      n.b     = bus.id_rs2_data; n.imm = bus.id_imm;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("id_stall", 32'(bus.id_stall), 32'(rst_n && (hazard(m) || !bus.ex_ready)));
      chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
      chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.rw));
      chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.mr));
      chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
      if (m.valid) begin
        chk("ex_rs1", 32'(bus.ex_rs1), 32'(m.rs1));
        chk("ex_rs2", 32'(bus.ex_rs2), 32'(m.rs2));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m.op));
        chk("ex_op_a", 32'(bus.ex_op_a), 32'(pick(bus.forward_a, m.a)));
        chk("ex_op_b", 32'(bus.ex_op_b), 32'(m.imm_en ? m.imm : pick(bus.forward_b, m.b)));
        chk("ex_store_data", 32'(bus.ex_store_data), 32'(pick(bus.forward_b, m.b)));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 1'b0;  bus.id_rs1 = R0; bus.id_rs2 = R0; bus.id_rd = R0;
    bus.id_rs1_data = W_Z; bus.id_rs2_data = W_Z; bus.id_imm = W_Z;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
    bus.id_use_rs2 = 1'b0; bus.id_use_imm = 1'b0; bus.id_alu_op = 4'h0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
    bus.forward_a = 2'b00; bus.forward_b = 2'b00;
    bus.mem_result = W_Z; bus.wb_result = W_Z;
  endtask

  task automatic id_inst(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                         input logic rw, input logic mr, input logic u2, input logic ui,
                         input word_t d1, input word_t d2, input word_t im,
                         input logic [3:0] op);
    bus.id_valid = 1'b1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_reg_write = rw; bus.id_mem_read = mr;
    bus.id_use_rs2 = u2; bus.id_use_imm = ui;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = im;
    bus.id_alu_op = op;
  endtask

  function automatic word_t rword();
    word_t w;
    for (int i = 0; i < WT; i++) w[i] = trit_t'($urandom_range(0, 2));
    return w;
  endfunction

  function automatic reg_addr_t raddr();
    case ($urandom_range(0, 3))
      0:       return R0;
      1:       return R1;
      2:       return R2;
      default: return R3;
    endcase
  endfunction

  initial begin
    idle_inputs();
    bus.ex_ready = 1'b0;
    step(); step();
    chk("rst_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_op_a", 32'(bus.ex_op_a), 32'd0);
    bus.ex_ready = 1'b1;
    rst_n = 1'b1;
    started = 1'b1;

    // Capture ADD rd=(+,0,0), then async reset in the middle of a stall
    id_inst(R2, R4, R3, 1'b1, 1'b0, 1'b1, 1'b0, W_A, W_B, W_Z, 4'h1);
    step();
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_rd", 32'(bus.ex_rd), 32'h10);
    chk("add_op_a", 32'(bus.ex_op_a), 32'(W_A));
    chk("add_store", 32'(bus.ex_store_data), 32'(W_B));
    bus.ex_ready = 1'b0;
    #1;
    chk("bp_stall", 32'(bus.id_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(bus.id_stall), 32'd0);
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_rd", 32'(bus.ex_rd), 32'd0);
    chk("arst_rw", 32'(bus.ex_reg_write), 32'd0);
    chk("arst_alu", 32'(bus.ex_alu_op), 32'd0);
    chk("arst_op_a", 32'(bus.ex_op_a), 32'd0);
    step();
    rst_n = 1'b1;
    idle_inputs();

    // Load-use on rs1=(0,0,+): one stall, bubble, then MEM forward
    id_inst(R0, R0, R1, 1'b1, 1'b1, 1'b0, 1'b0, W_S, W_Z, W_Z, 4'h2);
    step();
    chk("ld_mem_read", 32'(bus.ex_mem_read), 32'd1);
    chk("ld_rd", 32'(bus.ex_rd), 32'h01);
    id_inst(R1, R3, R2, 1'b1, 1'b0, 1'b0, 1'b0, W_B, W_Z, W_Z, 4'h3);
    #1;
    chk("lu_stall", 32'(bus.id_stall), 32'd1);
    step();
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_release", 32'(bus.id_stall), 32'd0);
    bus.forward_a = 2'b10;
    bus.mem_result = W_M;
    step();
    chk("lu_capture", 32'(bus.ex_rd), 32'h04);
    chk("lu_fwd_mem", 32'(bus.ex_op_a), 32'(W_M));
    bus.forward_a = 2'b00;

    // Load to R0 never stalls a reader of R0
    id_inst(R0, R0, R0, 1'b1, 1'b1, 1'b0, 1'b0, W_Z, W_Z, W_Z, 4'h2);
    step();
    id_inst(R0, R0, R3, 1'b1, 1'b0, 1'b0, 1'b0, W_A, W_Z, W_Z, 4'h4);
    #1;
    chk("r0_nostall", 32'(bus.id_stall), 32'd0);
    step();
    chk("r0_capture_valid", 32'(bus.ex_valid), 32'd1);
    chk("r0_capture_rd", 32'(bus.ex_rd), 32'h10);

    // Backpressure with WB forward on B: value must survive WB retiring
    id_inst(R2, R4, R1, 1'b1, 1'b0, 1'b1, 1'b0, W_A, W_S, W_Z, 4'h5);
    step();
    chk("bp_pre_store", 32'(bus.ex_store_data), 32'(W_S));
    bus.ex_ready = 1'b0;
    bus.forward_b = 2'b01;
    bus.wb_result = W_W;
    id_inst(R3, R0, R2, 1'b1, 1'b0, 1'b0, 1'b0, W_B, W_Z, W_Z, 4'h6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_alu", 32'(bus.ex_alu_op), 32'h5);
      chk("bp_hold_stall", 32'(bus.id_stall), 32'd1);
    end
    bus.forward_b = 2'b00;
    bus.wb_result = W_W2;
    #1;
    chk("bp_wb_kept", 32'(bus.ex_store_data), 32'(W_W));
    bus.ex_ready = 1'b1;
    step();
    chk("bp_next_alu", 32'(bus.ex_alu_op), 32'h6);

    // Flush wins over load-use and backpressure
    id_inst(R0, R0, R1, 1'b1, 1'b1, 1'b0, 1'b0, W_Z, W_Z, W_Z, 4'h2);
    step();
    id_inst(R1, R0, R3, 1'b1, 1'b0, 1'b0, 1'b0, W_A, W_Z, W_Z, 4'h3);
    bus.flush = 1'b1;
    bus.ex_ready = 1'b0;
    #1;
    chk("fl_stall", 32'(bus.id_stall), 32'd1);
    step();
    chk("fl_bubble", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;

    // Immediate on B while store data follows the MEM forward
    id_inst(R2, R4, R3, 1'b1, 1'b0, 1'b0, 1'b1, W_A, W_B, W_IMM, 4'h7);
    bus.forward_b = 2'b10;
    bus.mem_result = W_M2;
    step();
    chk("imm_op_b", 32'(bus.ex_op_b), 32'(W_IMM));
    chk("imm_store", 32'(bus.ex_store_data), 32'(W_M2));
    bus.forward_b = 2'b00;

    for (int n = 0; n < 3000; n++) begin
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_rs1       = raddr();
      bus.id_rs2       = raddr();
      bus.id_rd        = raddr();
      bus.id_rs1_data  = rword();
      bus.id_rs2_data  = rword();
      bus.id_imm       = rword();
      bus.id_reg_write = 1'($urandom_range(0, 1));
      bus.id_mem_read  = ($urandom_range(0, 2) == 0);
      bus.id_use_rs2   = 1'($urandom_range(0, 1));
      bus.id_use_imm   = 1'($urandom_range(0, 1));
      bus.id_alu_op    = 4'($urandom_range(0, 15));
      bus.flush        = ($urandom_range(0, 15) == 0);
      bus.ex_ready     = ($urandom_range(0, 3) != 0);
      bus.forward_a    = 2'($urandom_range(0, 3));
      bus.forward_b    = 2'($urandom_range(0, 3));
      bus.mem_result   = rword();
      bus.wb_result    = rword();
      step();
    end

    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
